contador_display: RTL and testbench



---
 rtl/contador_pkg.sv | 55 +++++
 rtl/contador_display_seg7_decoder.sv | 17 +
 rtl/contador_display.sv | 263 ++++++++++++++++++++++++++
 tb/tb_contador_display.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/contador_pkg.sv
// -----------------------------------------------------------------------------
// contador_pkg
//
// Shared definitions for the counter display slice:
//   SEG_OFF        - active-low segment word with every segment dark
//   AN_*           - active-low anode patterns for the two-digit display
//   GLYPHS         - active-low 7-segment glyphs for 0..F, bit order {g,f,e,d,c,b,a}
//   digit_t        - which digit the scan is currently driving
//   blink_state_t  - states of the wrap blink FSM
//   cnt_width()    - width of a counter that must hold 0..n-1 (never below 1)
// -----------------------------------------------------------------------------
package contador_pkg;

    localparam logic [6:0] SEG_OFF  = 7'h7F;

    localparam logic [1:0] AN_NONE  = 2'b11;
    localparam logic [1:0] AN_UNITS = 2'b10;
    localparam logic [1:0] AN_TENS  = 2'b01;

    // Index = nibble value. A 0 bit lights the segment.
    localparam logic [6:0] GLYPHS [16] = '{
        7'h40,  // 0
        7'h79,  // 1
        7'h24,  // 2
        7'h30,  // 3
        7'h19,  // 4
        7'h12,  // 5
        7'h02,  // 6
        7'h78,  // 7
        7'h00,  // 8
        7'h10,  // 9
        7'h08,  // A
        7'h03,  // b
        7'h46,  // C
        7'h21,  // d
        7'h06,  // E
        7'h0E   // F
    };

    typedef enum logic {
        UNITS = 1'b0,
        TENS  = 1'b1
    } digit_t;

    typedef enum logic {
        IDLE  = 1'b0,
        BLINK = 1'b1
    } blink_state_t;

    // $clog2(1) is 0, which would give a zero-width counter.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/contador_display_seg7_decoder.sv
// -----------------------------------------------------------------------------
// seg7_decoder
//
// Purely combinational nibble to 7-segment glyph lookup.
//   nibble_i [3:0] : value to show, 0..F
//   seg_o    [6:0] : active-low segments {g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
module seg7_decoder
    import contador_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    assign seg_o = GLYPHS[nibble_i];

endmodule

// File: rtl/contador_display.sv
// -----------------------------------------------------------------------------
// contador_display
//
// Shows the 4-bit up/down counter value on a two-digit, time-multiplexed,
// common-anode 7-segment display, flags counter wrap-around and blinks the
// display for a fixed interval after every wrap.
//
// Ports
//   clock      in   system clock, rising edge
//   reset      in   asynchronous, active-low reset
//   valor[3:0] in   counter value 0..15
//   seg[6:0]   out  segments, active-low, {g,f,e,d,c,b,a}
//   an[1:0]    out  anodes, active-low; an[0]=units, an[1]=tens
//   wrap_up    out  one-cycle pulse on a 15->0 transition
//   wrap_down  out  one-cycle pulse on a 0->15 transition
//   blinking   out  high while the blink FSM is in BLINK (also its state)
//
// Parameters
//   SCAN_DIV       cycles each digit is driven before switching (>=2)
//   BLINK_HALF     cycles per blink half-period (>=1)
//   BLINK_TOGGLES  blink half-periods per wrap event (even, >=2)
//
// Build option
//   CONTADOR_DISPLAY_HEX_EN : when defined, the units digit shows the value as
//   a single hex digit 0..F and the tens digit is never enabled. Wrap
//   detection and blinking are the same in both builds.
// -----------------------------------------------------------------------------
module contador_display
    import contador_pkg::*;
#(
    parameter int SCAN_DIV      = 1000,
    parameter int BLINK_HALF    = 5_000_000,
    parameter int BLINK_TOGGLES = 6
)(
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] valor,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       wrap_up,
    output logic       wrap_down,
    output logic       blinking
);

    localparam int SCAN_W = cnt_width(SCAN_DIV);
    localparam int HALF_W = cnt_width(BLINK_HALF);
    localparam int TOG_W  = cnt_width(BLINK_TOGGLES);

    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(BLINK_HALF - 1);
    localparam logic [TOG_W-1:0]  TOG_LAST  = TOG_W'(BLINK_TOGGLES - 1);

    // ------------------------------------------------------------------
    // Input stage and wrap detection
    // ------------------------------------------------------------------
    logic [3:0] v_q;
    logic [3:0] v_prev_q;
    logic       sampled_q;   // v_q holds a real sample
    logic       primed_q;    // v_prev_q holds a real sample
    logic       wrap_up_q;
    logic       wrap_down_q;

    // v_prev_q only carries a genuine sample from the second edge after
    // reset release; until then it is the reset value 0, and a counter
    // sitting at 15 would otherwise look like a 0->15 wrap.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            v_q         <= 4'd0;
            v_prev_q    <= 4'd0;
            sampled_q   <= 1'b0;
            primed_q    <= 1'b0;
            wrap_up_q   <= 1'b0;
            wrap_down_q <= 1'b0;
        end else begin
            v_q         <= valor;
            v_prev_q    <= v_q;
            sampled_q   <= 1'b1;
            primed_q    <= sampled_q;
            wrap_up_q   <= primed_q && (v_prev_q == 4'd15) && (v_q == 4'd0);
            wrap_down_q <= primed_q && (v_prev_q == 4'd0)  && (v_q == 4'd15);
        end
    end

    assign wrap_up   = wrap_up_q;
    assign wrap_down = wrap_down_q;

    logic wrap_any;
    assign wrap_any = wrap_up_q | wrap_down_q;

    // ------------------------------------------------------------------
    // Digit scan
    // ------------------------------------------------------------------
    logic [SCAN_W-1:0] scan_cnt_q;
    logic [SCAN_W-1:0] scan_cnt_d;
    digit_t            digit_q;
    digit_t            digit_d;

    always_comb begin
        scan_cnt_d = scan_cnt_q + 1'b1;
        digit_d    = digit_q;
        if (scan_cnt_q == SCAN_LAST) begin
            scan_cnt_d = '0;
            digit_d    = (digit_q == UNITS) ? TENS : UNITS;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            scan_cnt_q <= '0;
            digit_q    <= UNITS;
        end else begin
            scan_cnt_q <= scan_cnt_d;
            digit_q    <= digit_d;
        end
    end

    // ------------------------------------------------------------------
    // Digit selection and decode
    // ------------------------------------------------------------------
    logic [3:0] dec_nibble;
    logic [6:0] dec_seg;

`ifndef CONTADOR_DISPLAY_HEX_EN
    logic       tens;
    logic [3:0] units;
    assign tens  = (v_q >= 4'd10);
    assign units = tens ? (v_q - 4'd10) : v_q;
`endif

    // The single decoder is shared by both digits; the tens digit can only
    // ever be 1, so that slot just feeds it a constant.
    always_comb begin
        dec_nibble = 4'd1;
        if (digit_q == UNITS) begin
`ifdef CONTADOR_DISPLAY_HEX_EN
            dec_nibble = v_q;
`else
            dec_nibble = units;
`endif
        end
    end

    seg7_decoder u_seg7_decoder (
        .nibble_i (dec_nibble),
        .seg_o    (dec_seg)
    );

    logic [6:0] seg_q;
    logic [6:0] seg_d;
    logic [1:0] an_q;
    logic [1:0] an_d;

    always_comb begin
        seg_d = SEG_OFF;
        an_d  = AN_NONE;
        if (digit_q == UNITS) begin
            an_d  = AN_UNITS;
            seg_d = dec_seg;
        end else begin
`ifndef CONTADOR_DISPLAY_HEX_EN
            // Leading zero is blanked but the anode is still driven so the
            // scan duty cycle stays the same for every value.
            an_d = AN_TENS;
            if (tens) begin
                seg_d = dec_seg;
            end
`endif
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            seg_q <= SEG_OFF;
            an_q  <= AN_NONE;
        end else begin
            seg_q <= seg_d;
            an_q  <= an_d;
        end
    end

    // ------------------------------------------------------------------
    // Blink FSM: state register / next state / outputs
    // ------------------------------------------------------------------
    blink_state_t      state_q;
    blink_state_t      state_d;
    logic [HALF_W-1:0] half_cnt_q;
    logic [HALF_W-1:0] half_cnt_d;
    logic [TOG_W-1:0]  tog_cnt_q;
    logic [TOG_W-1:0]  tog_cnt_d;
    logic              phase_q;
    logic              phase_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            half_cnt_q <= '0;
            tog_cnt_q  <= '0;
            phase_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            half_cnt_q <= half_cnt_d;
            tog_cnt_q  <= tog_cnt_d;
            phase_q    <= phase_d;
        end
    end

    // A wrap pulse always (re)starts a full blink interval, whether the FSM
    // is idle or already blinking.
    always_comb begin
        state_d    = state_q;
        half_cnt_d = half_cnt_q;
        tog_cnt_d  = tog_cnt_q;
        phase_d    = phase_q;
        case (state_q)
            IDLE: begin
                if (wrap_any) begin
                    state_d    = BLINK;
                    half_cnt_d = '0;
                    tog_cnt_d  = '0;
                    phase_d    = 1'b0;
                end
            end
            BLINK: begin
                if (wrap_any) begin
                    half_cnt_d = '0;
                    tog_cnt_d  = '0;
                    phase_d    = 1'b0;
                end else if (half_cnt_q == HALF_LAST) begin
                    half_cnt_d = '0;
                    if (tog_cnt_q == TOG_LAST) begin
                        state_d   = IDLE;
                        tog_cnt_d = '0;
                        phase_d   = 1'b0;
                    end else begin
                        tog_cnt_d = tog_cnt_q + 1'b1;
                        phase_d   = ~phase_q;
                    end
                end else begin
                    half_cnt_d = half_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d    = IDLE;
                half_cnt_d = '0;
                tog_cnt_d  = '0;
                phase_d    = 1'b0;
            end
        endcase
    end

    logic blank;

    always_comb begin
        blinking = (state_q == BLINK);
        blank    = (state_q == BLINK) && phase_q;
    end

    // Blanking is applied after the output register so the dark half-periods
    // line up exactly with the blink FSM; the scan underneath keeps running.
    assign seg = blank ? SEG_OFF : seg_q;
    assign an  = blank ? AN_NONE : an_q;

endmodule

// File: tb/tb_contador_display.sv
module tb_contador_display;

  localparam int SCAN_DIV      = 4;
  localparam int BLINK_HALF    = 8;
  localparam int BLINK_TOGGLES = 4;
  localparam int BLINK_LEN     = BLINK_HALF * BLINK_TOGGLES;
  localparam int W             = 17;   // {is_down, cycle[15:0]}

  // ---------------- clock / reset ----------------
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] valor = 4'd0;
  logic [6:0] seg;
  logic [1:0] an;
  logic       wrap_up;
  logic       wrap_down;
  logic       blinking;

  always #5 clock = ~clock;

  contador_display #(
    .SCAN_DIV      (SCAN_DIV),
    .BLINK_HALF    (BLINK_HALF),
    .BLINK_TOGGLES (BLINK_TOGGLES)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .valor     (valor),
    .seg       (seg),
    .an        (an),
    .wrap_up   (wrap_up),
    .wrap_down (wrap_down),
    .blinking  (blinking)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int           pulse_times[$];
  logic [3:0]   hist [0:8191];   // hist[k] = valor sampled at edge k after release
  int           cyc = 0;         // edges since reset release
  int           n_checks = 0;
  int           n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s t=%0d actual=%0h required=%0h", name, cyc, act, req);
    end
  endtask

  // Segment glyphs described by which segments are lit.
  function automatic logic [6:0] glyph(input int d);
    string lit;
    logic [6:0] m;
    case (d)
      0: lit = "abcdef";   1: lit = "bc";      2: lit = "abdeg";   3: lit = "abcdg";
      4: lit = "bcfg";     5: lit = "acdfg";   6: lit = "acdefg";  7: lit = "abc";
      8: lit = "abcdefg";  9: lit = "abcdfg";  10: lit = "abcefg"; 11: lit = "cdefg";
      12: lit = "adef";    13: lit = "bcdeg";  14: lit = "adefg";  default: lit = "aefg";
    endcase
    m = 7'h7F;
    for (int i = 0; i < lit.len(); i++) m[int'(lit[i]) - 97] = 1'b0;
    return m;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic cycle(input logic [3:0] v);
    int k;
    k = cyc + 1;
    valor = v;
    hist[k] = v;
    if (k >= 2) begin
      if (hist[k-1] == 4'd15 && v == 4'd0) begin
        exp_q.push_back({1'b0, 16'(k + 1)});
        pulse_times.push_back(k + 1);
      end else if (hist[k-1] == 4'd0 && v == 4'd15) begin
        exp_q.push_back({1'b1, 16'(k + 1)});
        pulse_times.push_back(k + 1);
      end
    end
    @(posedge clock);
    #1;
    cyc = k;
  endtask

  task automatic hold(input logic [3:0] v, input int n);
    for (int i = 0; i < n; i++) cycle(v);
  endtask

  task automatic do_reset(input logic [3:0] v);
    reset = 1'b0;
    valor = v;
    #1;
    chk("async_rst_seg", 32'(seg), 32'h7F);
    chk("async_rst_an", 32'(an), 32'h3);
    chk("async_rst_blink", 32'(blinking), 32'h0);
    chk("async_rst_wrap", 32'({wrap_up, wrap_down}), 32'h0);
    @(posedge clock);
    @(posedge clock);
    #1;
    exp_q.delete();
    pulse_times.delete();
    cyc = 0;
    reset = 1'b1;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clock) begin
    if (!reset || cyc == 0) begin
      chk("rst_seg", 32'(seg), 32'h7F);
      chk("rst_an", 32'(an), 32'h3);
      chk("rst_blink", 32'(blinking), 32'h0);
      chk("rst_wrap", 32'({wrap_up, wrap_down}), 32'h0);
    end else begin
      int val;
      int d;
      int ph;
      logic blink_e;
      logic [6:0] seg_e;
      logic [1:0] an_e;
      logic [W-1:0] e;

      // wrap pulses
      if (wrap_up || wrap_down) begin
        if (wrap_up && wrap_down) begin
          chk("wrap_both", 32'({wrap_up, wrap_down}), 32'h1);
        end else if (exp_q.size() == 0) begin
          chk("wrap_unexpected", 32'({wrap_up, wrap_down}), 32'h0);
        end else begin
          e = exp_q.pop_front();
          chk(wrap_down ? "wrap_down" : "wrap_up", 32'({wrap_down, 16'(cyc)}), 32'(e));
        end
      end else if (exp_q.size() > 0 && int'(exp_q[0][15:0]) <= cyc) begin
        e = exp_q.pop_front();
        chk(e[16] ? "wrap_down_missing" : "wrap_up_missing", 32'h0, 32'h1);
      end

      // blink model: the latest wrap pulse decides everything
      blink_e = 1'b0;
      ph = 0;
      for (int i = pulse_times.size() - 1; i >= 0; i--) begin
        if (pulse_times[i] < cyc) begin
          if (cyc - pulse_times[i] <= BLINK_LEN) begin
            blink_e = 1'b1;
            ph = ((cyc - pulse_times[i] - 1) / BLINK_HALF) % 2;
          end
          break;
        end
      end

      // display model
      val = (cyc >= 2) ? int'(hist[cyc-1]) : 0;
      d = ((cyc - 1) / SCAN_DIV) % 2;
      if (blink_e && ph == 1) begin
        seg_e = 7'h7F;
        an_e  = 2'b11;
      end else if (d == 0) begin
        an_e = 2'b10;
`ifdef CONTADOR_DISPLAY_HEX_EN
        seg_e = glyph(val);
`else
        seg_e = glyph(val % 10);
`endif
      end else begin
`ifdef CONTADOR_DISPLAY_HEX_EN
        an_e  = 2'b11;
        seg_e = 7'h7F;
`else
        an_e  = 2'b01;
        seg_e = (val >= 10) ? glyph(1) : 7'h7F;
`endif
      end
      chk("blinking", 32'(blinking), 32'(blink_e));
      chk(d == 0 ? "seg_units" : "seg_tens", 32'(seg), 32'(seg_e));
      chk(d == 0 ? "an_units" : "an_tens", 32'(an), 32'(an_e));
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    #2;
    do_reset(4'd0);
    hold(4'd7, 12);                 // 07: units 7, tens blank
    hold(4'd13, 12);                // 13: units 3, tens 1
    hold(4'd11, 20);                // 11, or b in hex build
    cycle(4'd14);
    cycle(4'd15);
    hold(4'd0, 40);                 // single wrap_up and a full blink
    cycle(4'd15);                   // wrap_down
    hold(4'd15, 11);
    hold(4'd0, 45);                 // wrap_up mid-blink retriggers
    do_reset(4'd15);
    hold(4'd15, 10);                // no spurious wrap_down after release
    hold(4'd0, 12);                 // wrap_up, then reset mid-blink
    do_reset(4'd0);
    hold(4'd5, 10);

    for (int i = 0; i < 700; i++) begin
      logic [3:0] v;
      if (i == 350) do_reset(4'($urandom_range(0, 15)));
      if ($urandom_range(0, 9) < 4) v = ($urandom_range(0, 1) == 1) ? 4'd15 : 4'd0;
      else v = 4'($urandom_range(0, 15));
      hold(v, $urandom_range(1, 6));
    end

    hold(4'd8, 6);
    chk("sb_drain", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
